// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage sitting directly in front of decode. It owns the
// program counter and keeps at most one request outstanding to instruction
// memory. Returned words land in the IF/ID output slot. A 1-entry skid buffer
// catches a word that returns while decode is stalled.
// A redirect (taken branch/jump) reloads the pc. It also flushes the output
// slot, the skid buffer and any request still in flight.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   reset        asynchronous, active-high reset
//   stall        decode cannot accept; instrOut/pcOut/instrValid hold
//   redirect     load redirectPc into the pc and flush
//   redirectPc   redirect target (low two bits ignored)
//   imemReq      request strobe, memory accepts on every edge it is high
//   imemAddr     request address (current pc)
//   imemValid    one-cycle response strobe from memory
//   imemData     instruction word returned with imemValid
//   instrOut     instruction presented to decode
//   pcOut        address of instrOut
//   instrValid   instrOut/pcOut hold a real instruction
// ---------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h00000000,
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirectPc,
   output logic        imemReq,
   output logic [31:0] imemAddr,
   input  logic        imemValid,
   input  logic [31:0] imemData,
   output logic [31:0] instrOut,
   output logic [31:0] pcOut,
   output logic        instrValid
);

   // REQ: ready to issue, WAIT: request outstanding,
   // DROP: request outstanding but its answer belongs to a flushed path
   typedef enum logic [1:0] {REQ, WAIT, DROP} fetchState_t;

   fetchState_t state;
   logic [31:0] pc;
   logic [31:0] skidData;
   logic [31:0] skidPc;
   logic        skidValid;
   logic        slotFree;
   logic        respTake;

   // The output slot can take a new word when it is empty or decode is
   // consuming the current one on this edge.
   assign slotFree = !instrValid || !stall;

   // A response is only meaningful while waiting on a live request; answers
   // seen in REQ (stale after reset) or DROP are thrown away.
   assign respTake = (state == WAIT) && imemValid;

   // The request strobe must react to redirect in the same cycle so that no
   // fetch from the wrong path is ever accepted. A full skid buffer also holds
   // off new requests, because there would be nowhere to put the answer.
   assign imemReq  = !reset && (state == REQ) && !skidValid && !redirect;
   assign imemAddr = pc;

   // Single state register for the whole stage. The redirect branch comes
   // first so it beats stall and any same-cycle response. If a request is
   // still in flight when a redirect hits, the stage parks in DROP until the
   // orphaned answer shows up, keeping the one-outstanding rule intact.
   // Otherwise the skid buffer drains ahead of a fresh response. Both can
   // never be pending together, since no request is issued while the skid
   // is full.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= REQ;
         pc         <= RESET_PC;
         instrOut   <= NOP_INSTR;
         pcOut      <= RESET_PC;
         instrValid <= 1'b0;
         skidData   <= NOP_INSTR;
         skidPc     <= RESET_PC;
         skidValid  <= 1'b0;
      end else if (redirect) begin
         pc         <= redirectPc & ~32'h00000003;
         instrValid <= 1'b0;
         instrOut   <= NOP_INSTR;
         skidValid  <= 1'b0;
         if (((state == WAIT) || (state == DROP)) && !imemValid) begin
            state <= DROP;
         end else begin
            state <= REQ;
         end
      end else begin
         case (state)
            REQ: begin
               if (imemReq) begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (imemValid) begin
                  pc    <= pc + 32'd4;
                  state <= REQ;
               end
            end
            DROP: begin
               if (imemValid) begin
                  state <= REQ;
               end
            end
            default: state <= REQ;
         endcase

         if (slotFree) begin
            if (skidValid) begin
               instrOut   <= skidData;
               pcOut      <= skidPc;
               instrValid <= 1'b1;
               skidValid  <= 1'b0;
            end else if (respTake) begin
               instrOut   <= imemData;
               pcOut      <= pc;
               instrValid <= 1'b1;
            end else begin
               instrValid <= 1'b0;
               instrOut   <= NOP_INSTR;
            end
         end else if (respTake) begin
            skidData  <= imemData;
            skidPc    <= pc;
            skidValid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed scenarios followed by a randomized run of fetch_unit. A small
// instruction memory model answers requests with a configurable latency.
// The reference model works on the instruction stream: it tracks the next
// address that should be fetched and a queue of instructions fetched but not
// yet consumed. An epoch counter marks in-flight requests orphaned by
// redirect or reset. A second instance with RESET_PC = 32'hFFFFFFFC shares all
// inputs and is used to look at pc wrap-around.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

   localparam logic [31:0] NOP      = 32'h00000013;
   localparam logic [31:0] WRAP_PC  = 32'hFFFFFFFC;
   localparam logic [31:0] DATA_KEY = 32'hA5A50000;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect;
   logic [31:0] redirectPc;
   logic        imemValid;
   logic [31:0] imemData;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic [31:0] instrOut;
   logic [31:0] pcOut;
   logic        instrValid;
   logic        wrapImemReq;
   logic [31:0] wrapImemAddr;
   logic [31:0] wrapInstrOut;
   logic [31:0] wrapPcOut;
   logic        wrapInstrValid;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .redirect   (redirect),
      .redirectPc (redirectPc),
      .imemReq    (imemReq),
      .imemAddr   (imemAddr),
      .imemValid  (imemValid),
      .imemData   (imemData),
      .instrOut   (instrOut),
      .pcOut      (pcOut),
      .instrValid (instrValid)
   );

   fetch_unit #(.RESET_PC(WRAP_PC)) dutWrap (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .redirect   (redirect),
      .redirectPc (redirectPc),
      .imemReq    (wrapImemReq),
      .imemAddr   (wrapImemAddr),
      .imemValid  (imemValid),
      .imemData   (imemData),
      .instrOut   (wrapInstrOut),
      .pcOut      (wrapPcOut),
      .instrValid (wrapInstrValid)
   );

   int checks = 0;
   int errors = 0;
   int consumedCount = 0;

   // memory model state
   bit          memBusy;
   int          memLeft;
   int          memLatency;
   int          memEpoch;
   logic [31:0] memAddr;
   bit          randomData;

   // reference model state
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;
   entry_t      expQ[$];
   int          epoch;
   logic [31:0] expFetchPc;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic checkBit(input string tag, input logic observed, input logic expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
      end
   endtask

   // Check the output slot of the main instance
   task automatic checkSlot(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] p);
      checkBit({tag, ".valid"}, instrValid, v);
      if (v) begin
         checkOutput({tag, ".instr"}, instrOut, ins);
         checkOutput({tag, ".pc"}, pcOut, p);
      end else begin
         checkOutput({tag, ".nop"}, instrOut, NOP);
      end
   endtask

   // Check the request interface of the main instance
   task automatic checkReq(input string tag, input logic r, input logic [31:0] addr);
      checkBit({tag, ".req"}, imemReq, r);
      if (r) checkOutput({tag, ".addr"}, imemAddr, addr);
   endtask

   // Memory model update, called just after each rising edge
   task automatic memEdge(input logic respNow, input logic accepted, input logic [31:0] reqA);
      if (respNow) begin
         imemValid = 1'b0;
         memBusy   = 1'b0;
      end else if (memBusy) begin
         memLeft--;
         if (memLeft == 0) imemValid = 1'b1;
      end
      if (accepted) begin
         memBusy  = 1'b1;
         memLeft  = memLatency - 1;
         memAddr  = reqA;
         memEpoch = epoch;
         imemData = randomData ? $urandom : (reqA ^ DATA_KEY);
         if (memLeft == 0) imemValid = 1'b1;
      end
   endtask

   // Asserts reset mid-cycle, checks it acts immediately, holds it for
   // holdEdges rising edges (memory keeps running) and releases it mid-cycle.
   task automatic applyReset(input int holdEdges);
      logic respNow;
      reset = 1'b1;
      #1;
      checkBit("rst.valid", instrValid, 1'b0);
      checkOutput("rst.instr", instrOut, NOP);
      checkOutput("rst.pc", pcOut, 32'h0);
      checkBit("rst.req", imemReq, 1'b0);
      checkBit("rst.wrapValid", wrapInstrValid, 1'b0);
      checkOutput("rst.wrapInstr", wrapInstrOut, NOP);
      checkOutput("rst.wrapPc", wrapPcOut, WRAP_PC);
      epoch++;
      expQ.delete();
      expFetchPc = 32'h0;
      repeat (holdEdges) begin
         respNow = imemValid;
         @(posedge clk);
         #1;
         memEdge(respNow, 1'b0, 32'h0);
         @(negedge clk);
      end
      reset = 1'b0;
      #1;
   endtask

   // One clock cycle: drive inputs, predict this edge with the stream model,
   // advance the memory, then check the outputs after the edge.
   task automatic applyStimulus(input logic s, input logic r, input logic [31:0] rpc);
      logic        accepted;
      logic        respNow;
      logic        holdValid;
      logic [31:0] reqA;
      logic [31:0] holdInstr;
      logic [31:0] holdPc;
      entry_t      e;
      stall      = s;
      redirect   = r;
      redirectPc = rpc;
      #1;
      accepted  = imemReq;
      reqA      = imemAddr;
      respNow   = imemValid;
      holdValid = instrValid && s && !r;
      holdInstr = instrOut;
      holdPc    = pcOut;
      if (r) checkBit("noReqOnRedirect", imemReq, 1'b0);
      if (accepted) begin
         checkOutput("reqAddr", reqA, expFetchPc);
         checkBit("memIdleAtReq", memBusy && !respNow, 1'b0);
      end
      if (instrValid && !s && !r) begin
         consumedCount++;
         checkBit("consumeAvail", expQ.size() > 0, 1'b1);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("consumePc", pcOut, e.pc);
            checkOutput("consumeInstr", instrOut, e.instr);
         end
      end
      if (r) begin
         epoch++;
         expQ.delete();
         expFetchPc = rpc & ~32'h3;
      end
      if (respNow && memBusy && (memEpoch == epoch)) begin
         expQ.push_back('{pc: memAddr, instr: imemData});
         expFetchPc = memAddr + 32'd4;
      end
      @(posedge clk);
      #1;
      memEdge(respNow, accepted, reqA);
      @(negedge clk);
      if (!instrValid) checkOutput("nopWhenEmpty", instrOut, NOP);
      if (holdValid) begin
         checkBit("stallHoldValid", instrValid, 1'b1);
         checkOutput("stallHoldInstr", instrOut, holdInstr);
         checkOutput("stallHoldPc", pcOut, holdPc);
      end
      redirect = 1'b0;
      #1;
   endtask

   initial begin
      int consumedBefore;
      reset      = 1'b1;
      stall      = 1'b0;
      redirect   = 1'b0;
      redirectPc = 32'h0;
      imemValid  = 1'b0;
      imemData   = 32'h0;
      memBusy    = 1'b0;
      memLeft    = 0;
      memLatency = 1;
      memEpoch   = 0;
      memAddr    = 32'h0;
      randomData = 1'b0;
      epoch      = 0;
      expFetchPc = 32'h0;
      @(negedge clk);
      applyReset(2);

      // plain streaming with a 1-cycle memory, plus wrap on the second instance
      checkReq("t1.first", 1'b1, 32'h0);
      checkOutput("t1.wrapAddr0", wrapImemAddr, WRAP_PC);
      checkBit("t1.wrapReq0", wrapImemReq, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkSlot("t1.empty", 1'b0, 32'h0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkSlot("t1.i0", 1'b1, 32'hA5A50000, 32'h0);
      checkReq("t1.r1", 1'b1, 32'h4);
      checkOutput("t1.wrapPc", wrapPcOut, WRAP_PC);
      checkOutput("t1.wrapAddr1", wrapImemAddr, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkSlot("t1.i1", 1'b1, 32'hA5A50004, 32'h4);
      checkReq("t1.r2", 1'b1, 32'h8);
      applyStimulus(1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkSlot("t1.i2", 1'b1, 32'hA5A50008, 32'h8);

      // stall after the first instruction; second response goes to the skid
      applyReset(1);
      applyStimulus(1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkSlot("t2.first", 1'b1, 32'hA5A50000, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkReq("t2.skidBlocks", 1'b0, 32'h0);
      repeat (3) applyStimulus(1'b1, 1'b0, 32'h0);
      checkSlot("t2.frozen", 1'b1, 32'hA5A50000, 32'h0);
      checkReq("t2.stillBlocked", 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkSlot("t2.drain", 1'b1, 32'hA5A50004, 32'h4);
      checkReq("t2.resume", 1'b1, 32'h8);

      // redirect while a 2-cycle request is outstanding
      memLatency = 2;
      applyStimulus(1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b1, 32'h00000103);
      checkSlot("t3.flush", 1'b0, 32'h0, 32'h0);
      checkReq("t3.dropWait", 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkSlot("t3.lateDropped", 1'b0, 32'h0, 32'h0);
      checkReq("t3.target", 1'b1, 32'h00000100);
      applyStimulus(1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkSlot("t3.pending", 1'b0, 32'h0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkSlot("t3.arrive", 1'b1, 32'hA5A50100, 32'h00000100);

      // redirect together with stall and a full skid buffer
      memLatency = 1;
      applyStimulus(1'b1, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkReq("t4.skidFull", 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b1, 32'h0000020A);
      checkSlot("t4.flush", 1'b0, 32'h0, 32'h0);
      checkReq("t4.target", 1'b1, 32'h00000208);
      applyStimulus(1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkSlot("t4.arrive", 1'b1, 32'hA5A50208, 32'h00000208);

      // reset while waiting on a 3-cycle memory; stale answer shows up in REQ
      memLatency = 3;
      applyStimulus(1'b0, 1'b0, 32'h0);
      applyReset(2);
      checkReq("t6.fresh", 1'b1, 32'h0);
      memLatency = 1;
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkSlot("t6.staleIgnored", 1'b0, 32'h0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkSlot("t6.arrive", 1'b1, 32'hA5A50000, 32'h0);

      // randomized traffic against the stream model
      randomData = 1'b1;
      for (int i = 0; i < 600; i++) begin
         memLatency = int'($urandom_range(1, 3));
         applyStimulus($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, $urandom);
      end

      // with no stall or redirect the stage must keep delivering
      consumedBefore = consumedCount;
      repeat (20) applyStimulus(1'b0, 1'b0, 32'h0);
      checkBit("drainProgress", consumedCount > consumedBefore, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
